// File: rtl/rggen_irq_coalescer.sv
// rggen_irq_coalescer
// Watches W0C/W1C interrupt-status fields (masked by per-bit enables) and
// raises one level interrupt once enough new events have accumulated or a
// timeout has elapsed since the first event of a burst.
//
// Handshake: none. Inputs are level-sampled every rising edge; outputs are
// registered and change only on the rising edge after the inputs that cause
// them. There are no combinational paths from inputs to outputs.
module rggen_irq_coalescer #(
  parameter int WIDTH       = 1,
  parameter int COUNT_WIDTH = 8,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       i_status,
  input  logic [WIDTH-1:0]       i_enable,
  input  logic [COUNT_WIDTH-1:0] i_threshold,
  input  logic [TIMER_WIDTH-1:0] i_timeout,
  output logic                   o_irq,
  output logic [COUNT_WIDTH-1:0] o_event_count
);

  // Width of the per-cycle new-event count, and of a sum that cannot overflow.
  localparam int NW = $clog2(WIDTH + 1);
  localparam int SW = ((COUNT_WIDTH > NW) ? COUNT_WIDTH : NW) + 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ASSERT  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         prev_masked_q;
  logic [WIDTH-1:0]         masked;
  logic [WIDTH-1:0]         new_evt;
  logic [NW-1:0]            n_new;
  logic [SW-1:0]            sum_wide;
  logic [COUNT_WIDTH-1:0]   cnt_sum;
  logic [COUNT_WIDTH-1:0]   n_new_sat;
  logic [COUNT_WIDTH-1:0]   thr;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
  logic                     irq_q;

  // Masking, edge detection of pending bits, and a popcount of new events.
  always_comb begin
    masked  = i_status & i_enable;
    new_evt = masked & ~prev_masked_q;
    n_new   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n_new = n_new + NW'(new_evt[i]);
    end
  end

  // Saturating accumulation and the effective threshold (0 behaves as 1).
  always_comb begin
    sum_wide  = SW'(count_q) + SW'(n_new);
    cnt_sum   = (sum_wide > SW'(CNT_MAX)) ? CNT_MAX : sum_wide[COUNT_WIDTH-1:0];
    n_new_sat = (SW'(n_new) > SW'(CNT_MAX)) ? CNT_MAX : COUNT_WIDTH'(n_new);
    thr       = (i_threshold == '0) ? COUNT_WIDTH'(1) : i_threshold;
  end

  // Next-state logic: count, timer and state transitions.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (new_evt != '0) begin
          count_d = n_new_sat;
          if (SW'(n_new) >= SW'(thr)) begin
            state_d = ASSERT;
          end else begin
            state_d = COLLECT;
            timer_d = i_timeout;
          end
        end
      end
      COLLECT: begin
        if (masked == '0) begin
          // Software cleared everything pending before the burst matured.
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
        end else begin
          count_d = cnt_sum;
          if (cnt_sum >= thr) begin
            state_d = ASSERT;
          end else if ((i_timeout != '0) && (timer_q == TIMER_WIDTH'(1))) begin
            state_d = ASSERT;
          end else if (timer_q != '0) begin
            timer_d = timer_q - TIMER_WIDTH'(1);
          end
        end
      end
      ASSERT: begin
        if (masked == '0) begin
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
        end else begin
          count_d = cnt_sum;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // State, counters, history of masked bits, and the registered request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      timer_q       <= '0;
      prev_masked_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      prev_masked_q <= masked;
      irq_q         <= (state_d == ASSERT);
    end
  end

  assign o_irq         = irq_q;
  assign o_event_count = count_q;

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Bench for rggen_irq_coalescer: two instances (8-bit and 2-bit counters)
// share one stimulus stream; an event-level model is compared every cycle,
// and directed checkpoints pin hand-computed values.
module tb_rggen_irq_coalescer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  status;
  logic [3:0]  enable;
  logic [7:0]  thr_in;
  logic [15:0] tmo;
  logic        irq_a, irq_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rggen_irq_coalescer #(.WIDTH(4), .COUNT_WIDTH(8), .TIMER_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_status(status), .i_enable(enable),
    .i_threshold(thr_in), .i_timeout(tmo), .o_irq(irq_a), .o_event_count(cnt_a)
  );

  rggen_irq_coalescer #(.WIDTH(4), .COUNT_WIDTH(2), .TIMER_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_status(status), .i_enable(enable),
    .i_threshold(thr_in[1:0]), .i_timeout(tmo), .o_irq(irq_b), .o_event_count(cnt_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Event-level model. Phase 0 = quiet, 1 = burst collecting, 2 = raised.
  // The timeout is tracked as an absolute deadline cycle.
  int cyc = 0;
  int m_ph[2], m_cnt[2], m_prev[2], m_dead[2];
  int cmax[2]    = '{255, 3};
  int thr_mod[2] = '{256, 4};

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_cnt[k] = 0; m_prev[k] = 0; m_dead[k] = 0;
    end
  end

  always @(posedge clk) begin : model_blk
    int pend, nn, th, sum;
    cyc  = cyc + 1;
    pend = int'(status & enable);
    for (int k = 0; k < 2; k++) begin
      nn  = $countones(pend & ~m_prev[k]);
      th  = int'(thr_in) % thr_mod[k];
      if (th == 0) th = 1;
      sum = (m_cnt[k] + nn > cmax[k]) ? cmax[k] : m_cnt[k] + nn;
      if (!rst_n) begin
        m_ph[k] = 0; m_cnt[k] = 0; m_prev[k] = 0;
      end else begin
        if (m_ph[k] == 0) begin
          if (nn > 0) begin
            m_cnt[k]  = (nn > cmax[k]) ? cmax[k] : nn;
            m_ph[k]   = (nn >= th) ? 2 : 1;
            m_dead[k] = cyc + int'(tmo);
          end
        end else if (pend == 0) begin
          m_ph[k] = 0; m_cnt[k] = 0;
        end else begin
          m_cnt[k] = sum;
          if (m_ph[k] == 1 && (sum >= th || (tmo != 0 && cyc == m_dead[k])))
            m_ph[k] = 2;
        end
        m_prev[k] = pend;
      end
    end
  end

  // Compare process: outputs against the model every cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_irq_a", int'(irq_a), (m_ph[0] == 2) ? 1 : 0);
      chk("cmp_cnt_a", int'(cnt_a), m_cnt[0]);
      chk("cmp_irq_b", int'(irq_b), (m_ph[1] == 2) ? 1 : 0);
      chk("cmp_cnt_b", int'(cnt_b), m_cnt[1]);
    end
  end

  // Directed stimulus with hand-computed checkpoints.
  initial begin
    rst_n = 1'b0; status = 4'h0; enable = 4'h0; thr_in = 8'd3; tmo = 16'd0;
    step(3);
    started = 1;
    chk("rst_irq", int'(irq_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    rst_n = 1'b1; enable = 4'hF;
    step(2);

    // threshold path: three events spaced two cycles apart
    status = 4'h1; step(1);
    chk("t1_cnt1", int'(cnt_a), 1);
    chk("t1_irq0", int'(irq_a), 0);
    step(1); status = 4'h3; step(2);
    chk("t1_cnt2", int'(cnt_a), 2);
    status = 4'h7; step(1);
    chk("t1_irq1", int'(irq_a), 1);
    chk("t1_cnt3", int'(cnt_a), 3);
    status = 4'h0; step(1);
    chk("t1_clr_irq", int'(irq_a), 0);
    chk("t1_clr_cnt", int'(cnt_a), 0);
    step(2);

    // timeout path: single event, thr=8, timeout=5
    thr_in = 8'd8; tmo = 16'd5;
    status = 4'h1; step(5);
    chk("t2_irq_e4", int'(irq_a), 0);
    step(1);
    chk("t2_irq_e5", int'(irq_a), 1);
    chk("t2_cnt", int'(cnt_a), 1);
    status = 4'h0; step(2);

    // burst cancelled by software before the timeout
    status = 4'h1; step(2);
    status = 4'h0; step(1);
    chk("t3_cnt", int'(cnt_a), 0);
    step(6);
    chk("t3_irq", int'(irq_a), 0);

    // one bit cleared and another set in the same cycle
    tmo = 16'd0;
    status = 4'h1; step(2);
    status = 4'h2; step(1);
    chk("sim_cnt", int'(cnt_a), 2);
    chk("sim_irq", int'(irq_a), 0);
    status = 4'h0; step(2);

    // thr=0 behaves as 1; four bits at once with thr=4
    thr_in = 8'd0;
    status = 4'h2; step(1);
    chk("t4_thr0_irq", int'(irq_a), 1);
    chk("t4_thr0_cnt", int'(cnt_a), 1);
    status = 4'h0; step(2);
    thr_in = 8'd4;
    status = 4'hF; step(1);
    chk("t4_burst_irq", int'(irq_a), 1);
    chk("t4_burst_cnt", int'(cnt_a), 4);
    chk("t4_burst_cnt_b", int'(cnt_b), 3);
    status = 4'h0; step(2);

    // saturation: six more events while raised
    thr_in = 8'd3;
    status = 4'h7; step(1);
    chk("t5_irq", int'(irq_b), 1);
    for (int i = 0; i < 6; i++) begin
      status = 4'hF; step(1);
      status = 4'h7; step(1);
    end
    chk("t5_cnt_a", int'(cnt_a), 9);
    chk("t5_cnt_b_sat", int'(cnt_b), 3);
    status = 4'h0; step(2);

    // enable-edge event, then reset while raised
    thr_in = 8'd1;
    enable = 4'h0; status = 4'h1; step(2);
    chk("t6_pre_irq", int'(irq_a), 0);
    enable = 4'hF; step(1);
    chk("t6_en_irq", int'(irq_a), 1);
    chk("t6_en_cnt", int'(cnt_a), 1);
    rst_n = 1'b0; step(1);
    chk("t6_rst_irq", int'(irq_a), 0);
    chk("t6_rst_cnt", int'(cnt_a), 0);
    rst_n = 1'b1; step(1);
    chk("t6_rel_irq", int'(irq_a), 1);
    chk("t6_rel_cnt", int'(cnt_a), 1);
    status = 4'h0; step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
